// File: rtl/lottery_pkg.sv
// Shared types for the lottery round controller: digit type, round FSM states
// and a helper that extracts one digit from a packed ticket/draw bus.
package lottery_pkg;

  localparam int NDIG = 10;

  typedef logic [3:0] digit_t;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    SCORE,
    DRAIN,
    SUMMARY
  } round_state_e;

  // Digit idx sits at bus[4*idx+3:4*idx]; a constant-index scan keeps selects static.
  function automatic digit_t unpack_digit(input logic [4*NDIG-1:0] bus, input int idx);
    digit_t d;
    d = '0;
    for (int j = 0; j < NDIG; j++) begin
      if (j == idx) d = bus[4*j +: 4];
    end
    return d;
  endfunction

endpackage

// File: rtl/lottery_round_ctrl_payout.sv
// Digit comparator: flags every position where the drawn digit equals the
// ticket digit. Masking and counting are left to the caller.
module payout
  import lottery_pkg::*;
(
  input  logic [4*NDIG-1:0] i_id,
  input  logic [4*NDIG-1:0] i_in,
  output logic [NDIG-1:0]   o_match
);

  always_comb begin
    o_match = '0;
    for (int i = 0; i < NDIG; i++) begin
      o_match[i] = (unpack_digit(i_id, i) == unpack_digit(i_in, i));
    end
  end

endmodule

// File: rtl/lottery_round_ctrl.sv
// Lottery round sequencer: serial draw capture, one-ticket-per-cycle scoring with
// a single-entry result register, saturating round statistics and a summary pulse.
module lottery_round_ctrl
  import lottery_pkg::*;
#(
  parameter int TKT_W = 8,
  parameter int TOT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              draw_start,
  input  logic              draw_vld,
  input  logic [3:0]        draw_digit,
  input  logic              tkt_vld,
  output logic              tkt_rdy,
  input  logic [4*NDIG-1:0] tkt_digits,
  input  logic [NDIG-1:0]   tkt_en,
  output logic              res_vld,
  input  logic              res_rdy,
  output logic [TKT_W-1:0]  res_id,
  output logic [3:0]        res_payout,
  output logic              res_jackpot,
  input  logic              close,
  output logic              sum_vld,
  output logic [TKT_W-1:0]  sum_tickets,
  output logic [TOT_W-1:0]  sum_total,
  output logic [TKT_W-1:0]  sum_jackpots,
  output logic              busy
);

  function automatic logic [3:0] count_hits(input logic [NDIG-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NDIG; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  function automatic logic [TKT_W-1:0] sat_inc(input logic [TKT_W-1:0] a, input logic b);
    return (a == '1) ? a : a + TKT_W'(b);
  endfunction

  function automatic logic [TOT_W-1:0] sat_add(input logic [TOT_W-1:0] a, input logic [3:0] b);
    logic [TOT_W:0] s;
    s = {1'b0, a} + (TOT_W+1)'(b);
    return s[TOT_W] ? '1 : s[TOT_W-1:0];
  endfunction

  round_state_e      r_state;
  logic [4*NDIG-1:0] r_draw;
  logic [3:0]        r_idx;
  logic [TKT_W-1:0]  r_id_cnt;
  logic [TKT_W-1:0]  r_tickets;
  logic [TOT_W-1:0]  r_total;
  logic [TKT_W-1:0]  r_jackpots;
  logic              r_vld_p1;
  logic [TKT_W-1:0]  r_id_p1;
  logic [3:0]        r_payout_p1;
  logic              r_jackpot_p1;

  logic [NDIG-1:0]   w_match;
  logic [NDIG-1:0]   w_hit;
  logic [3:0]        w_payout_p0;
  logic              w_jackpot_p0;
  logic              w_rdy;
  logic              w_accept;

  payout u_payout (
    .i_id    (r_draw),
    .i_in    (tkt_digits),
    .o_match (w_match)
  );

  // ---- stage p0: mask the comparator result with the play mask ----
  assign w_hit        = w_match & tkt_en;
  assign w_payout_p0  = count_hits(w_hit);
  assign w_jackpot_p0 = (tkt_en != '0) && (w_hit == tkt_en);

  // The result register may be refilled in the very cycle it is drained.
  assign w_rdy    = (r_state == SCORE) && (!r_vld_p1 || res_rdy);
  assign w_accept = tkt_vld && w_rdy;

  // ---- stage p1: registered result and round state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_draw       <= '0;
      r_idx        <= '0;
      r_id_cnt     <= '0;
      r_tickets    <= '0;
      r_total      <= '0;
      r_jackpots   <= '0;
      r_vld_p1     <= 1'b0;
      r_id_p1      <= '0;
      r_payout_p1  <= '0;
      r_jackpot_p1 <= 1'b0;
    end else begin
      if (w_accept) begin
        r_vld_p1     <= 1'b1;
        r_id_p1      <= r_id_cnt;
        r_payout_p1  <= w_payout_p0;
        r_jackpot_p1 <= w_jackpot_p0;
        r_id_cnt     <= r_id_cnt + TKT_W'(1);
        r_tickets    <= sat_inc(r_tickets, 1'b1);
        r_total      <= sat_add(r_total, w_payout_p0);
        r_jackpots   <= sat_inc(r_jackpots, w_jackpot_p0);
      end else if (r_vld_p1 && res_rdy) begin
        r_vld_p1 <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (draw_start) begin
            r_state    <= DRAW;
            r_idx      <= '0;
            r_id_cnt   <= '0;
            r_tickets  <= '0;
            r_total    <= '0;
            r_jackpots <= '0;
          end
        end
        DRAW: begin
          if (draw_vld) begin
            for (int k = 0; k < NDIG; k++) begin
              if (r_idx == 4'(k)) r_draw[4*k +: 4] <= draw_digit;
            end
            if (r_idx == 4'(NDIG - 1)) begin
              r_idx   <= '0;
              r_state <= SCORE;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        SCORE: begin
          if (close) r_state <= DRAIN;
        end
        DRAIN: begin
          if (!r_vld_p1) r_state <= SUMMARY;
        end
        SUMMARY: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tkt_rdy      = w_rdy;
  assign res_vld      = r_vld_p1;
  assign res_id       = r_id_p1;
  assign res_payout   = r_payout_p1;
  assign res_jackpot  = r_jackpot_p1;
  assign sum_vld      = (r_state == SUMMARY);
  assign sum_tickets  = r_tickets;
  assign sum_total    = r_total;
  assign sum_jackpots = r_jackpots;
  assign busy         = (r_state != IDLE);

endmodule
